// File: rtl/a5_pkg.sv
// rtl/a5_pkg.sv - shared types, default geometry and helpers for the A5/1 burst engine
package a5_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_KEY,
        LOAD_FRAME,
        MIX,
        RUN,
        DRAIN
    } state_t;

    localparam int              A5_REG1LEN     = 19;
    localparam int              A5_REG2LEN     = 22;
    localparam int              A5_REG3LEN     = 23;
    localparam logic [18:0]     A5_MASK1       = 19'h72000;
    localparam logic [21:0]     A5_MASK2       = 22'h300000;
    localparam logic [22:0]     A5_MASK3       = 23'h700080;
    localparam int              A5_SYNCBIT1    = 8;
    localparam int              A5_SYNCBIT2    = 10;
    localparam int              A5_SYNCBIT3    = 10;
    localparam int              A5_KEYLEN      = 64;
    localparam int              A5_FRAMENUMLEN = 22;
    localparam int              A5_MIXCYCLES   = 100;
    localparam int              A5_CHUNKLEN    = 114;

    // Majority vote of the three clocking bits.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Largest of three sizes; used to dimension the shared phase counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/a5_lfsr.sv
// rtl/a5_lfsr.sv - one A5/1 shift register with load injection and step-aware output bit
module a5_lfsr
    import a5_pkg::*;
#(
    parameter int                REGLEN     = A5_REG1LEN,
    parameter logic [REGLEN-1:0] FEEDBACK   = REGLEN'(A5_MASK1),
    parameter int                SYNCBITPOS = A5_SYNCBIT1
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic step_en,
    input  logic ld,
    output logic msb,
    output logic syncbit
);

    logic [REGLEN-1:0] r;
    logic              fb;

    assign fb      = ^(r & FEEDBACK);
    // Clocking decision is made on the current contents.
    assign syncbit = r[SYNCBITPOS];
    // Keystream is taken from the post-step register, so when stepping this
    // cycle the bit that will become the MSB is the one just below it.
    assign msb     = step_en ? r[REGLEN-2] : r[REGLEN-1];

    // Shift register: cleared at session start, steps when enabled.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r <= '0;
        end else if (step_en) begin
            r <= {r[REGLEN-2:0], fb ^ ld};
        end
    end

endmodule

// File: rtl/a5_burst_engine.sv
// rtl/a5_burst_engine.sv - A5/1 session setup and handshaked keystream XOR; optional A5_DUPLEX_EN adds a second burst
module a5_burst_engine
    import a5_pkg::*;
#(
    parameter int                 REG1LEN     = A5_REG1LEN,
    parameter int                 REG2LEN     = A5_REG2LEN,
    parameter int                 REG3LEN     = A5_REG3LEN,
    parameter logic [REG1LEN-1:0] MASK1       = A5_MASK1,
    parameter logic [REG2LEN-1:0] MASK2       = A5_MASK2,
    parameter logic [REG3LEN-1:0] MASK3       = A5_MASK3,
    parameter int                 SYNCBIT1    = A5_SYNCBIT1,
    parameter int                 SYNCBIT2    = A5_SYNCBIT2,
    parameter int                 SYNCBIT3    = A5_SYNCBIT3,
    parameter int                 KEYLEN      = A5_KEYLEN,
    parameter int                 FRAMENUMLEN = A5_FRAMENUMLEN,
    parameter int                 MIXCYCLES   = A5_MIXCYCLES,
    parameter int                 CHUNKLEN    = A5_CHUNKLEN
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [KEYLEN-1:0]      key,
    input  logic [FRAMENUMLEN-1:0] frame,
    output logic                   busy,
    input  logic                   in_valid,
    input  logic                   in_bit,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic                   out_bit,
    input  logic                   out_ready,
    output logic                   done
`ifdef A5_DUPLEX_EN
    ,
    output logic                   burst_sel
`endif
);

    localparam int CNT_MAX = max3(KEYLEN, MIXCYCLES, 2 * CHUNKLEN);
    localparam int CW      = $clog2(CNT_MAX + 1);

`ifdef A5_DUPLEX_EN
    localparam int BURST_BITS = 2 * CHUNKLEN;
    localparam logic [CW-1:0] CHUNK_CNT = CW'(CHUNKLEN);
`else
    localparam int BURST_BITS = CHUNKLEN;
`endif

    localparam logic [CW-1:0] KEY_LAST   = CW'(KEYLEN - 1);
    localparam logic [CW-1:0] FRAME_LAST = CW'(FRAMENUMLEN - 1);
    localparam logic [CW-1:0] MIX_LAST   = CW'(MIXCYCLES - 1);
    localparam logic [CW-1:0] BIT_LAST   = CW'(BURST_BITS - 1);

    state_t                 state, state_nxt;
    logic [CW-1:0]          cnt;
    logic [KEYLEN-1:0]      key_q;
    logic [FRAMENUMLEN-1:0] frame_q;

    logic cnt_clr, cnt_inc;
    logic capture, key_shift, frame_shift;
    logic lfsr_clear, step_all, step_maj, ld;
    logic xfer, done_set;

    logic msb1, msb2, msb3;
    logic sync1, sync2, sync3;
    logic maj, gamma;
    logic step1, step2, step3;

    assign maj   = maj3(sync1, sync2, sync3);
    assign step1 = step_all | (step_maj & (sync1 == maj));
    assign step2 = step_all | (step_maj & (sync2 == maj));
    assign step3 = step_all | (step_maj & (sync3 == maj));
    assign gamma = msb1 ^ msb2 ^ msb3;

    a5_lfsr #(.REGLEN(REG1LEN), .FEEDBACK(MASK1), .SYNCBITPOS(SYNCBIT1)) u_lfsr1 (
        .clock   (clock),
        .reset   (reset),
        .clear   (lfsr_clear),
        .step_en (step1),
        .ld      (ld),
        .msb     (msb1),
        .syncbit (sync1)
    );

    a5_lfsr #(.REGLEN(REG2LEN), .FEEDBACK(MASK2), .SYNCBITPOS(SYNCBIT2)) u_lfsr2 (
        .clock   (clock),
        .reset   (reset),
        .clear   (lfsr_clear),
        .step_en (step2),
        .ld      (ld),
        .msb     (msb2),
        .syncbit (sync2)
    );

    a5_lfsr #(.REGLEN(REG3LEN), .FEEDBACK(MASK3), .SYNCBITPOS(SYNCBIT3)) u_lfsr3 (
        .clock   (clock),
        .reset   (reset),
        .clear   (lfsr_clear),
        .step_en (step3),
        .ld      (ld),
        .msb     (msb3),
        .syncbit (sync3)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, handshake and LFSR control for each phase of the session.
    always_comb begin
        state_nxt   = state;
        busy        = (state != IDLE);
        in_ready    = 1'b0;
        xfer        = 1'b0;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        capture     = 1'b0;
        key_shift   = 1'b0;
        frame_shift = 1'b0;
        lfsr_clear  = 1'b0;
        step_all    = 1'b0;
        step_maj    = 1'b0;
        ld          = 1'b0;
        done_set    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    capture    = 1'b1;
                    lfsr_clear = 1'b1;
                    cnt_clr    = 1'b1;
                    state_nxt  = LOAD_KEY;
                end
            end
            LOAD_KEY: begin
                step_all  = 1'b1;
                ld        = key_q[0];
                key_shift = 1'b1;
                cnt_inc   = 1'b1;
                if (cnt == KEY_LAST) begin
                    cnt_clr   = 1'b1;
                    state_nxt = LOAD_FRAME;
                end
            end
            LOAD_FRAME: begin
                step_all    = 1'b1;
                ld          = frame_q[0];
                frame_shift = 1'b1;
                cnt_inc     = 1'b1;
                if (cnt == FRAME_LAST) begin
                    cnt_clr   = 1'b1;
                    state_nxt = MIX;
                end
            end
            MIX: begin
                step_maj = 1'b1;
                cnt_inc  = 1'b1;
                if (cnt == MIX_LAST) begin
                    cnt_clr   = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                in_ready = !out_valid || out_ready;
                xfer     = in_valid && in_ready;
                step_maj = xfer;
                cnt_inc  = xfer;
                if (xfer && (cnt == BIT_LAST)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (out_valid && out_ready) begin
                    done_set  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Phase counter plus captured key/frame, consumed LSB first by shifting.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt     <= '0;
            key_q   <= '0;
            frame_q <= '0;
        end else begin
            if (cnt_clr) begin
                cnt <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + 1'b1;
            end
            if (capture) begin
                key_q   <= key;
                frame_q <= frame;
            end else begin
                if (key_shift) key_q <= key_q >> 1;
                if (frame_shift) frame_q <= frame_q >> 1;
            end
        end
    end

    // Output register: loads on transfer, empties when downstream accepts.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= done_set;
            if (xfer) begin
                out_valid <= 1'b1;
                out_bit   <= in_bit ^ gamma;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef A5_DUPLEX_EN
    // Burst tag travels with the bit it belongs to.
    always_ff @(posedge clock) begin
        if (reset) begin
            burst_sel <= 1'b0;
        end else if (xfer) begin
            burst_sel <= (cnt >= CHUNK_CNT);
        end
    end
`endif

endmodule

// File: tb/tb_a5_burst_engine.sv
// tb/tb_a5_burst_engine.sv - directed self-checking bench for a5_burst_engine
module tb_a5_burst_engine;

    localparam logic [63:0] KEY   = 64'hEFCDAB8967452312;
    localparam logic [21:0] FRAME = 22'h134;
`ifdef A5_DUPLEX_EN
    localparam int NBITS = 228;
`else
    localparam int NBITS = 114;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [63:0] key   = '0;
    logic [21:0] frame = '0;
    logic        busy;
    logic        in_valid = 1'b0;
    logic        in_bit   = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic        out_bit;
    logic        out_ready = 1'b0;
    logic        done;
`ifdef A5_DUPLEX_EN
    logic        burst_sel;
`endif

    int total = 0;
    int bad   = 0;
    int nbits;
    int ndone;
    int lat;
    logic got [0:255];
    logic sel [0:255];
    logic [119:0] ref_ks = 120'h534EAA582FE8151AB6E1855A728C00;
    logic [23:0]  ref_ul = 24'h24FD35;

    always #5 clock = ~clock;

    a5_burst_engine dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .key       (key),
        .frame     (frame),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_bit   (out_bit),
        .out_ready (out_ready),
        .done      (done)
`ifdef A5_DUPLEX_EN
        ,
        .burst_sel (burst_sel)
`endif
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic setup(input bit poke);
        bit seen;
        seen  = 1'b0;
        key   = KEY;
        frame = FRAME;
        start = 1'b1;
        lat   = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clock); #1;
            lat++;
            start = 1'b0;
            if (lat == 1) begin
                chk("busy_after_start", busy, 1'b1);
                if (poke) key = ~KEY;
            end
            if (poke && lat == 120) start = 1'b1;
            if (in_ready) begin
                seen = 1'b1;
                break;
            end
        end
        start = 1'b0;
        chk("setup_timeout", seen, 1'b1);
        chk("setup_latency", lat, 187);
    endtask

    task automatic stream(input bit bp, input int stop_at, input bit poke);
        logic prev_hold;
        logic prev_bit;
        bit   finished;
        nbits     = 0;
        ndone     = 0;
        prev_hold = 1'b0;
        prev_bit  = 1'b0;
        finished  = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (done) ndone++;
            if (prev_hold) begin
                chk("hold_valid", out_valid, 1'b1);
                chk("hold_bit", out_bit, prev_bit);
            end
            if (ndone > 0) begin
                finished = 1'b1;
                break;
            end
            if (stop_at >= 0 && nbits == stop_at) begin
                finished = 1'b1;
                break;
            end
            in_bit    = 1'b0;
            in_valid  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            start     = poke && (nbits == 20);
            #1;
            if (out_valid && out_ready) begin
                if (nbits < 256) begin
                    got[nbits] = out_bit;
`ifdef A5_DUPLEX_EN
                    sel[nbits] = burst_sel;
`else
                    sel[nbits] = 1'b0;
`endif
                end
                nbits++;
            end
            prev_hold = out_valid && !out_ready;
            prev_bit  = out_bit;
            @(posedge clock); #1;
        end
        start    = 1'b0;
        in_valid = 1'b0;
        chk("stream_timeout", finished, 1'b1);
    endtask

    task automatic check_burst();
        chk("bit_count", nbits, NBITS);
        chk("done_pulses", ndone, 1);
        chk("busy_after_done", busy, 1'b0);
        for (int i = 0; i < 114; i++) begin
            chk($sformatf("ks_bit%0d", i), got[i], ref_ks[119-i]);
        end
`ifdef A5_DUPLEX_EN
        chk("sel_first", sel[0], 1'b0);
        for (int i = 0; i < 24; i++) begin
            chk($sformatf("ul_bit%0d", i), got[114+i], ref_ul[23-i]);
            chk($sformatf("ul_sel%0d", i), sel[114+i], 1'b1);
        end
`endif
        out_ready = 1'b1;
        @(posedge clock); #1;
        chk("done_one_cycle", done, 1'b0);
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_bit", out_bit, 1'b0);
        chk("rst_done", done, 1'b0);
        reset = 1'b0;
        @(posedge clock); #1;

        setup(1'b1);
        stream(1'b0, -1, 1'b1);
        check_burst();

        setup(1'b0);
        stream(1'b1, -1, 1'b0);
        check_burst();

        setup(1'b0);
        stream(1'b0, 40, 1'b0);
        chk("mid_bits", nbits, 40);
        reset = 1'b1;
        @(posedge clock); #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_out_valid", out_valid, 1'b0);
        reset = 1'b0;
        @(posedge clock); #1;
        setup(1'b0);
        stream(1'b0, -1, 1'b0);
        check_burst();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
